twiddle_seq_gen: RTL and testbench

- Parametrised, sequential twiddle-factor generator for a radix-2 N-point FFT datapath (N = 2^LOG2N).
- On a start command for one butterfly stage, streams that stage's N/2 twiddle factors W_N^k over a valid/ready interface to the butterfly unit.
- Stores only a quarter-wave cosine table and derives all factors by symmetry.
- Supports forward and inverse (conjugated) twiddles; factors are packed as {real, imag}.

---
 rtl/twiddle_seq_gen.sv | 176 +++++++++++++++++
 tb/tb_twiddle_seq_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq_gen.sv
// Radix-2 FFT twiddle-factor sequencer: streams one stage's N/2 factors from a quarter-wave table.
// Optional DIF ordering and its `dif` port are enabled with `define TWSEQ_DIF_EN.
module twiddle_seq_gen #(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned W     = 12,
  parameter int unsigned SW    = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic [SW-1:0]    stage,
  input  logic             inverse,
`ifdef TWSEQ_DIF_EN
  input  logic             dif,
`endif
  output logic             busy,
  output logic             done,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic [2*W-1:0]   tw_data,
  output logic [LOG2N-2:0] tw_index,
  output logic             tw_last
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned NH = 2 ** (LOG2N - 1);
  localparam int unsigned Q  = 2 ** (LOG2N - 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // round(2^(W-2) * cos(2*pi*m/N)); Taylor series is exact enough for angles up to pi/2
  function automatic int cos_q(input int m);
    real x;
    real term;
    real sum;
    x    = 2.0 * 3.14159265358979323846 * $itor(m) / (2.0 ** LOG2N);
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 16; i++) begin
      term = -term * x * x / $itor((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return $rtoi(sum * (2.0 ** (W - 2)) + 0.5);
  endfunction

  logic signed [W-1:0] rom [Q+1];

  for (genvar m = 0; m <= Q; m++) begin : g_rom
    assign rom[m] = W'(cos_q(m));
  end

  state_e              state_q, state_d;
  logic [KW-1:0]       j_q, j_d;
  logic [SW-1:0]       s_q;
  logic                inv_q;
  logic                dif_q;
  logic                dif_in;
  logic [2*W-1:0]      data_q;
  logic [KW-1:0]       idx_q;
  logic                last_q;
  logic                accept;
  logic                load;

  logic [KW-1:0]       j_src;
  logic [KW-1:0]       k_nxt;
  logic [KW-1:0]       ones;
  logic [SW-1:0]       s_src;
  logic                inv_src;
  logic                dif_src;
  logic signed [W-1:0] re_nxt;
  logic signed [W-1:0] im_nxt;
  int unsigned         kq;

`ifdef TWSEQ_DIF_EN
  assign dif_in = dif;
`else
  assign dif_in = 1'b0;
`endif

  // Element for the next load: j=0 of a new request in IDLE, j+1 of the latched request in RUN
  always_comb begin
    ones = '1;
    if (state_q == StIdle) begin
      j_src   = '0;
      s_src   = stage;
      inv_src = inverse;
      dif_src = dif_in;
    end else begin
      j_src   = j_q + 1'b1;
      s_src   = s_q;
      inv_src = inv_q;
      dif_src = dif_q;
    end
    if (dif_src) begin
      k_nxt = (j_src & (ones >> s_src)) << s_src;
    end else begin
      k_nxt = (j_src & (ones >> (KW - s_src))) << (KW - s_src);
    end
    kq = 32'(k_nxt);
    if (kq <= Q) begin
      re_nxt = rom[KW'(kq)];
      im_nxt = -rom[KW'(Q - kq)];
    end else begin
      re_nxt = -rom[KW'(NH - kq)];
      im_nxt = -rom[KW'(kq - Q)];
    end
    if (inv_src) begin
      im_nxt = -im_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    accept  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (32'(stage) < LOG2N)) begin
          accept  = 1'b1;
          load    = 1'b1;
          j_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (tw_ready) begin
          if (j_q == KW'(NH - 1)) begin
            state_d = StDone;
          end else begin
            j_d  = j_q + 1'b1;
            load = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= StIdle;
      j_q     <= '0;
      s_q     <= '0;
      inv_q   <= 1'b0;
      dif_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      if (accept) begin
        s_q   <= stage;
        inv_q <= inverse;
        dif_q <= dif_in;
      end
      if (load) begin
        data_q <= {re_nxt, im_nxt};
        idx_q  <= k_nxt;
        last_q <= (j_src == KW'(NH - 1));
      end
    end
  end

  always_comb begin
    busy     = (state_q == StRun);
    tw_valid = (state_q == StRun);
    done     = (state_q == StDone);
    tw_last  = last_q && (state_q == StRun);
    tw_data  = data_q;
    tw_index = idx_q;
  end

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Directed bench for twiddle_seq_gen: LOG2N=4/W=12 main instance plus a LOG2N=3 instance,
// whose 2-bit stage port can express an out-of-range stage (3).
module tb_twiddle_seq_gen;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        start, inverse, tw_ready;
  logic [1:0]  stage;
  logic        busy, done, tw_valid, tw_last;
  logic [23:0] tw_data;
  logic [2:0]  tw_index;
`ifdef TWSEQ_DIF_EN
  logic        dif;
  logic        dif2;
`endif

  logic        start2, inverse2, tw_ready2;
  logic [1:0]  stage2;
  logic        busy2, done2, tw_valid2, tw_last2;
  logic [23:0] tw_data2;
  logic [1:0]  tw_index2;

  int total = 0;
  int bad   = 0;

  logic [23:0] fwd_tab [8] = '{24'h400000, 24'h3B2E78, 24'h2D4D2C, 24'h188C4E,
                               24'h000C00, 24'hE78C4E, 24'hD2CD2C, 24'hC4EE78};
  logic [23:0] inv_tab [8] = '{24'h400000, 24'h3B2188, 24'h2D42D4, 24'h1883B2,
                               24'h000400, 24'hE783B2, 24'hD2C2D4, 24'hC4E188};
  logic [23:0] n8_tab  [4] = '{24'h400000, 24'h2D4D2C, 24'h000C00, 24'hD2CD2C};

  twiddle_seq_gen #(.LOG2N(4), .W(12)) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .start    (start),
    .stage    (stage),
    .inverse  (inverse),
`ifdef TWSEQ_DIF_EN
    .dif      (dif),
`endif
    .busy     (busy),
    .done     (done),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_data  (tw_data),
    .tw_index (tw_index),
    .tw_last  (tw_last)
  );

  twiddle_seq_gen #(.LOG2N(3), .W(12)) dut2 (
    .clk      (clk),
    .reset_p  (reset_p),
    .start    (start2),
    .stage    (stage2),
    .inverse  (inverse2),
`ifdef TWSEQ_DIF_EN
    .dif      (dif2),
`endif
    .busy     (busy2),
    .done     (done2),
    .tw_valid (tw_valid2),
    .tw_ready (tw_ready2),
    .tw_data  (tw_data2),
    .tw_index (tw_index2),
    .tw_last  (tw_last2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one full sequence on the main instance; called and returns just after a rising edge.
  task automatic run_seq(input int s, input logic inv, input logic d, input bit stall,
                         input bit poke, input string tag);
    logic [23:0] hd;
    logic [2:0]  hk;
    logic [2:0]  ek;
    bit          stalled;
    int          n;
    start   = 1'b1;
    stage   = 2'(s);
    inverse = inv;
`ifdef TWSEQ_DIF_EN
    dif     = d;
`endif
    @(posedge clk); #1;
    start   = 1'b0;
    n       = 0;
    stalled = 1'b0;
    for (int c = 0; c < 64 && n < 8; c++) begin
      tw_ready = stall ? (c % 3 == 0) : 1'b1;
      if (poke) begin
        start = (c == 2 || c == 3);
        stage = 2'd0;
      end
      @(negedge clk);
      if (stalled) begin
        check({tag, "_hold_d"}, 32'(tw_data), 32'(hd));
        check({tag, "_hold_k"}, 32'(tw_index), 32'(hk));
      end
      stalled = 1'b0;
      if (tw_valid && tw_ready) begin
        if (d) ek = 3'((n % (1 << (3 - s))) << s);
        else   ek = 3'((n % (1 << s)) << (3 - s));
        check($sformatf("%s_k%0d", tag, n), 32'(tw_index), 32'(ek));
        check($sformatf("%s_d%0d", tag, n), 32'(tw_data), 32'(inv ? inv_tab[ek] : fwd_tab[ek]));
        check($sformatf("%s_l%0d", tag, n), 32'(tw_last), 32'(n == 7));
        n++;
      end else if (tw_valid) begin
        stalled = 1'b1;
        hd      = tw_data;
        hk      = tw_index;
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    tw_ready = 1'b1;
    check({tag, "_count"}, 32'(n), 32'd8);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_valid_at_done"}, 32'(tw_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset_p   = 1'b1;
    start     = 1'b0;
    stage     = 2'd0;
    inverse   = 1'b0;
    tw_ready  = 1'b0;
    start2    = 1'b0;
    stage2    = 2'd0;
    inverse2  = 1'b0;
    tw_ready2 = 1'b1;
`ifdef TWSEQ_DIF_EN
    dif       = 1'b0;
    dif2      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(tw_valid), 32'd0);
    check("rst_last", 32'(tw_last), 32'd0);
    check("rst_data", 32'(tw_data), 32'd0);
    check("rst_index", 32'(tw_index), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    @(posedge clk); #1;
    reset_p  = 1'b0;
    tw_ready = 1'b1;
    @(posedge clk); #1;

    run_seq(3, 1'b0, 1'b0, 1'b0, 1'b0, "s3");
    run_seq(1, 1'b0, 1'b0, 1'b0, 1'b0, "s1");
    run_seq(0, 1'b0, 1'b0, 1'b0, 1'b0, "s0");
    run_seq(2, 1'b0, 1'b0, 1'b0, 1'b0, "s2");
    run_seq(3, 1'b1, 1'b0, 1'b0, 1'b0, "s3inv");
    run_seq(3, 1'b0, 1'b0, 1'b1, 1'b1, "s3stall");

    // Asynchronous reset while element 5 (k=4) is on the bus
    start = 1'b1;
    stage = 2'd3;
    inverse = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_index", 32'(tw_index), 32'd4);
    reset_p = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(tw_valid), 32'd0);
    check("arst_data", 32'(tw_data), 32'd0);
    check("arst_index", 32'(tw_index), 32'd0);
    check("arst_last", 32'(tw_last), 32'd0);
    @(posedge clk); #1;
    reset_p = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_nodone%0d", c), 32'(done), 32'd0);
      check($sformatf("post_rst_idle%0d", c), 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    run_seq(3, 1'b0, 1'b0, 1'b0, 1'b0, "restart");

`ifdef TWSEQ_DIF_EN
    run_seq(0, 1'b0, 1'b1, 1'b0, 1'b0, "dif0");
    run_seq(3, 1'b0, 1'b1, 1'b0, 1'b0, "dif3");
`endif

    // N=8 instance: stage 3 is out of range and must be ignored
    start2 = 1'b1;
    stage2 = 2'd3;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    check("bad_stage_busy", 32'(busy2), 32'd0);
    check("bad_stage_valid", 32'(tw_valid2), 32'd0);
    @(posedge clk); #1;
    start2 = 1'b1;
    stage2 = 2'd2;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      @(negedge clk);
      if (tw_valid2 && tw_ready2) begin
        check($sformatf("n8_k%0d", n), 32'(tw_index2), 32'(n));
        check($sformatf("n8_d%0d", n), 32'(tw_data2), 32'(n8_tab[n]));
        check($sformatf("n8_l%0d", n), 32'(tw_last2), 32'(n == 3));
        n++;
      end
      @(posedge clk); #1;
    end
    check("n8_count", 32'(n), 32'd4);
    @(negedge clk);
    check("n8_done", 32'(done2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
